// File: rtl/mdu_pkg.sv
// Shared MDU definitions: opcode encodings (also used by the decoder),
// FSM state type, result bundle and the arithmetic helper.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Pending HI/LO result; wr is cleared when the op must not touch HI/LO
    // (divide by zero).
    typedef struct packed {
        logic        wr;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_res_t;

    // Full 64-bit result of a long MDU op, computed at issue time.
    function automatic mdu_res_t mdu_calc(input logic [3:0]  op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        mdu_res_t    res;
        logic [63:0] prod;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        res   = '0;
        prod  = '0;
        mag_a = '0;
        mag_b = '0;
        quo   = '0;
        rem   = '0;
        case (op)
            MDU_MULT: begin
                // Low 64 bits of the product of sign-extended operands are
                // the exact signed 32x32 product.
                prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res.wr = 1'b1;
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MDU_MULTU: begin
                prod   = {32'd0, a} * {32'd0, b};
                res.wr = 1'b1;
                res.hi = prod[63:32];
                res.lo = prod[31:0];
            end
            MDU_DIV: begin
                if (b != 32'd0) begin
                    // Divide magnitudes, then fix signs: quotient truncates
                    // toward zero, remainder takes the dividend's sign.
                    // 0x80000000 / -1 falls out as 0x80000000 rem 0.
                    mag_a  = a[31] ? (32'd0 - a) : a;
                    mag_b  = b[31] ? (32'd0 - b) : b;
                    quo    = mag_a / mag_b;
                    rem    = mag_a % mag_b;
                    res.wr = 1'b1;
                    res.lo = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
                    res.hi = a[31] ? (32'd0 - rem) : rem;
                end
            end
            MDU_DIVU: begin
                if (b != 32'd0) begin
                    res.wr = 1'b1;
                    res.lo = a / b;
                    res.hi = a % b;
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage command / result bundle between the pipeline and the MDU.
interface mdu_if;

    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_RD;

    modport master (
        output Start, MDUOp, A, B, Req,
        input  Busy, HI, LO, MDU_RD
    );

    modport slave (
        input  Start, MDUOp, A, B, Req,
        output Busy, HI, LO, MDU_RD
    );

endinterface

// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO, models mult/div latency with Busy,
// and drops side effects of ops cancelled by a CP0 request.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    mdu_res_t           r_tmp;

    logic               w_accept;
    logic               w_long_op;
    logic               w_is_mult;
    mdu_res_t           w_res;
    logic [31:0]        w_rd;

    // Decode the E-stage command and precompute the long-op result.
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && bus.Start && !bus.Req;
        w_is_mult = (bus.MDUOp == MDU_MULT) || (bus.MDUOp == MDU_MULTU);
        w_long_op = w_is_mult || (bus.MDUOp == MDU_DIV) || (bus.MDUOp == MDU_DIVU);
        w_res     = mdu_calc(bus.MDUOp, bus.A, bus.B);
    end

    // mfhi/mflo read port; shows committed HI/LO even while busy.
    always_comb begin
        w_rd = 32'd0;
        if (bus.MDUOp == MDU_MFHI) begin
            w_rd = r_hi;
        end else if (bus.MDUOp == MDU_MFLO) begin
            w_rd = r_lo;
        end
    end

    // IDLE/BUSY sequencer with registered Busy and HI/LO commit.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_tmp   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_long_op) begin
                            r_tmp   <= w_res;
                            r_cnt   <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            r_busy  <= 1'b1;
                            r_state <= ST_BUSY;
                        end else if (bus.MDUOp == MDU_MTHI) begin
                            r_hi <= bus.A;
                        end else if (bus.MDUOp == MDU_MTLO) begin
                            r_lo <= bus.A;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_tmp.wr) begin
                            r_hi <= r_tmp.hi;
                            r_lo <= r_tmp.lo;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy   = r_busy;
    assign bus.HI     = r_hi;
    assign bus.LO     = r_lo;
    assign bus.MDU_RD = w_rd;

endmodule
